// File: rtl/spi_baud_generator.sv
// ============================================================================
// Module   : spi_baud_generator
// Brief    : SPI master SCLK divider with polarity control and edge events.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_baud_generator (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       mstr,
  input  logic       spi_busy,
  input  logic       ss,
  input  logic       cpol,
  input  logic       cpha,
  input  logic [2:0] sppr,
  input  logic [2:0] spr,
  output logic       sclk,
  output logic       posedge_sclk_event,
  output logic       negedge_sclk_event,
  output logic       sample_event,
  output logic       shift_event,
  output logic       baud_active
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     r_state;
  logic [9:0] r_cnt;
  logic [9:0] r_hm1;
  logic       r_cpol;
  logic       r_cpha;
  logic       r_sclk;
  logic       r_pos;
  logic       r_neg;
  logic       r_sample;
  logic       r_shift;

  logic       w_active;
  logic [9:0] w_hm1_live;
  logic       w_tc;
  logic       w_lead;

  assign w_active = mstr & spi_busy & ~ss;

  // H-1 = sppr*2^spr + (2^spr - 1): the two terms occupy disjoint bits, max 1023.
  assign w_hm1_live = ({7'd0, sppr} << spr) | ~(10'h3FF << spr);

  assign w_tc   = (r_cnt == r_hm1);
  assign w_lead = (r_sclk == r_cpol);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 10'd0;
      r_hm1    <= 10'd0;
      r_cpol   <= 1'b0;
      r_cpha   <= 1'b0;
      r_sclk   <= 1'b0;
      r_pos    <= 1'b0;
      r_neg    <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
    end else begin
      r_pos    <= 1'b0;
      r_neg    <= 1'b0;
      r_sample <= 1'b0;
      r_shift  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt  <= 10'd0;
          r_sclk <= cpol;
          if (w_active) begin
            r_state <= ST_RUN;
            r_hm1   <= w_hm1_live;
            r_cpol  <= cpol;
            r_cpha  <= cpha;
            // The activation cycle is count 0, so H=1 toggles right away.
            if (w_hm1_live == 10'd0) begin
              r_sclk   <= ~cpol;
              r_pos    <= ~cpol;
              r_neg    <= cpol;
              r_sample <= ~cpha;
              r_shift  <= cpha;
            end else begin
              r_cnt <= 10'd1;
            end
          end
        end
        ST_RUN: begin
          if (!w_active) begin
            r_state <= ST_IDLE;
            r_cnt   <= 10'd0;
            r_sclk  <= cpol;
          end else if (w_tc) begin
            r_cnt    <= 10'd0;
            r_sclk   <= ~r_sclk;
            r_pos    <= ~r_sclk;
            r_neg    <= r_sclk;
            r_sample <= w_lead ^ r_cpha;
            r_shift  <= ~(w_lead ^ r_cpha);
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sclk               = r_sclk;
  assign posedge_sclk_event = r_pos;
  assign negedge_sclk_event = r_neg;
  assign sample_event       = r_sample;
  assign shift_event        = r_shift;
  assign baud_active        = (r_state == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_spi_baud_generator.sv
// ============================================================================
// Module   : tb_spi_baud_generator
// Brief    : Directed self-checking bench for spi_baud_generator.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_spi_baud_generator;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       mstr;
  logic       spi_busy;
  logic       ss;
  logic       cpol;
  logic       cpha;
  logic [2:0] sppr;
  logic [2:0] spr;
  logic       sclk;
  logic       posedge_sclk_event;
  logic       negedge_sclk_event;
  logic       sample_event;
  logic       shift_event;
  logic       baud_active;

  int n_cmp = 0;
  int n_err = 0;

  spi_baud_generator dut (
    .PCLK               (PCLK),
    .PRESETn            (PRESETn),
    .mstr               (mstr),
    .spi_busy           (spi_busy),
    .ss                 (ss),
    .cpol               (cpol),
    .cpha               (cpha),
    .sppr               (sppr),
    .spr                (spr),
    .sclk               (sclk),
    .posedge_sclk_event (posedge_sclk_event),
    .negedge_sclk_event (negedge_sclk_event),
    .sample_event       (sample_event),
    .shift_event        (shift_event),
    .baud_active        (baud_active)
  );

  always #5 PCLK = ~PCLK;

  // Observed vector: {sclk, pos, neg, sample, shift, baud_active}
  function automatic logic [5:0] obs();
    return {sclk, posedge_sclk_event, negedge_sclk_event,
            sample_event, shift_event, baud_active};
  endfunction

  // Expected vector k cycles after activation for half-period h.
  function automatic logic [5:0] exp_vec(int k, int h, logic pol, logic pha);
    logic lvl, ev, lead, smp, shf;
    ev   = ((k % h) == 0);
    lvl  = pol ^ ((k / h) % 2 == 1);
    lead = ev & (lvl != pol);
    smp  = pha ? (ev & ~lead) : lead;
    shf  = ev & ~smp;
    return {lvl, ev & lvl, ev & ~lvl, smp, shf, 1'b1};
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; mstr = 1'b1; spi_busy = 1'b0; ss = 1'b1;
    cpol = 1'b1; cpha = 1'b0; sppr = 3'd0; spr = 3'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs() !== 6'b000000) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: got %b want 000000", i, obs());
      end
    end
    PRESETn = 1'b1;
    step();
    n_cmp++;
    if (obs() !== 6'b100000) begin
      n_err++;
      $display("FAIL reset_release: got %b want 100000", obs());
    end
  endtask

  task automatic test_gating();
    cpol = 1'b0; ss = 1'b1; spi_busy = 1'b1;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_err++;
      $display("FAIL gate_ss_high: got %b want 000000", obs());
    end
    ss = 1'b0; mstr = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_err++;
      $display("FAIL gate_mstr_low: got %b want 000000", obs());
    end
    spi_busy = 1'b0; mstr = 1'b1;
    step();
  endtask

  task automatic test_divide12();
    sppr = 3'd2; spr = 3'd1; cpol = 1'b0; cpha = 1'b0;
    spi_busy = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_vec(k, 6, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL div12[k=%0d]: got %b want %b", k, obs(), exp_vec(k, 6, 1'b0, 1'b0));
      end
    end
    spi_busy = 1'b0;
    step();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_err++;
      $display("FAIL div12_idle: got %b want 000000", obs());
    end
  endtask

  task automatic test_mode3();
    cpol = 1'b1; cpha = 1'b1; sppr = 3'd0; spr = 3'd0;
    step();
    n_cmp++;
    if (obs() !== 6'b100000) begin
      n_err++;
      $display("FAIL mode3_idle: got %b want 100000", obs());
    end
    spi_busy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_vec(k, 1, 1'b1, 1'b1)) begin
        n_err++;
        $display("FAIL mode3[k=%0d]: got %b want %b", k, obs(), exp_vec(k, 1, 1'b1, 1'b1));
      end
    end
    // Reset asserted mid-RUN overrides everything.
    PRESETn = 1'b0;
    step();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_err++;
      $display("FAIL mode3_reset_midrun: got %b want 000000", obs());
    end
    PRESETn = 1'b1; spi_busy = 1'b0;
    step();
    n_cmp++;
    if (obs() !== 6'b100000) begin
      n_err++;
      $display("FAIL mode3_post_reset: got %b want 100000", obs());
    end
  endtask

  task automatic test_max_divisor();
    cpol = 1'b0; cpha = 1'b0; sppr = 3'd7; spr = 3'd7;
    step();
    spi_busy = 1'b1;
    for (int k = 1; k <= 2050; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_vec(k, 1024, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL maxdiv[k=%0d]: got %b want %b", k, obs(), exp_vec(k, 1024, 1'b0, 1'b0));
      end
    end
    spi_busy = 1'b0;
    step();
  endtask

  task automatic test_abort();
    cpol = 1'b0; cpha = 1'b0; sppr = 3'd2; spr = 3'd1;
    step();
    spi_busy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_vec(k, 6, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL abort_pre[k=%0d]: got %b want %b", k, obs(), exp_vec(k, 6, 1'b0, 1'b0));
      end
    end
    // Counter is 3 and sclk is high here.
    spi_busy = 1'b0;
    step();
    n_cmp++;
    if (obs() !== 6'b000000) begin
      n_err++;
      $display("FAIL abort_drop: got %b want 000000", obs());
    end
    spi_busy = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_vec(k, 6, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL abort_restart[k=%0d]: got %b want %b", k, obs(), exp_vec(k, 6, 1'b0, 1'b0));
      end
    end
    spi_busy = 1'b0;
    step();
  endtask

  task automatic test_config_change();
    cpol = 1'b0; cpha = 1'b1; sppr = 3'd2; spr = 3'd1;
    step();
    spi_busy = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k == 1) begin
        spr = 3'd3;
        cpha = 1'b0;
      end
      n_cmp++;
      if (obs() !== exp_vec(k, 6, 1'b0, 1'b1)) begin
        n_err++;
        $display("FAIL cfg_old[k=%0d]: got %b want %b", k, obs(), exp_vec(k, 6, 1'b0, 1'b1));
      end
    end
    spi_busy = 1'b0;
    step();
    spi_busy = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      step();
      n_cmp++;
      if (obs() !== exp_vec(k, 24, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL cfg_new[k=%0d]: got %b want %b", k, obs(), exp_vec(k, 24, 1'b0, 1'b0));
      end
    end
    spi_busy = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_gating();
    test_divide12();
    test_mode3();
    test_max_divisor();
    test_abort();
    test_config_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
